// File: rtl/fpu_host_if.sv
// Host-side initiator for the FPU command handshake: CPU byte registers, start/done/ack
// sequencing with timeout. Optional completion interrupt enabled by defining FPU_HOST_IRQ_EN.
module fpu_host_if #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        irq,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        fpu_ack
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_a, r_b, r_result, r_cnt;
    logic [3:0]  r_op;
    logic        r_done, r_err, r_tmo;
    logic        w_wr, w_busy, w_cmd_wr, w_cmd_ok, w_stat_wr, w_tmo_hit;
    logic        w_set_done, w_set_err, w_set_tmo, w_capture;
    logic        w_done_next, w_err_next, w_tmo_next, w_ie;

    assign w_wr      = cs & wr;
    assign w_busy    = (r_state != S_IDLE);
    assign w_cmd_wr  = w_wr && (addr == 4'h8);
    assign w_cmd_ok  = w_cmd_wr && !w_busy && (din[3:0] <= 4'd9);
    assign w_stat_wr = w_wr && (addr == 4'h9);
    // The count of the current cycle is included, so the abort lands exactly TIMEOUT_CYCLES after entry.
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt >= 32'(TIMEOUT_CYCLES - 1));

    assign w_capture  = (r_state == S_REQ) && fpu_done;
    assign w_set_done = (r_state == S_ACK) && !fpu_done;
    assign w_set_tmo  = w_tmo_hit && (((r_state == S_REQ) && !fpu_done) ||
                                      ((r_state == S_ACK) && fpu_done));
    assign w_set_err  = w_cmd_wr && (w_busy || (din[3:0] > 4'd9));

    // Hardware sets take priority over a software write-one-to-clear in the same cycle.
    assign w_done_next = w_set_done | (r_done & ~(w_stat_wr & din[1]));
    assign w_err_next  = w_set_err  | (r_err  & ~(w_stat_wr & din[2]));
    assign w_tmo_next  = w_set_tmo  | (r_tmo  & ~(w_stat_wr & din[3]));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_ok) w_state_next = S_REQ;
            S_REQ: begin
                if (fpu_done)       w_state_next = S_ACK;
                else if (w_tmo_hit) w_state_next = S_IDLE;
            end
            S_ACK: begin
                if (!fpu_done)      w_state_next = S_IDLE;
                else if (w_tmo_hit) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fpu_start = 1'b0;
        fpu_ack   = 1'b0;
        case (r_state)
            S_REQ:   fpu_start = 1'b1;
            S_ACK:   fpu_ack   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            if (w_wr && !w_busy) begin
                case (addr)
                    4'h0: r_a[7:0]   <= din;
                    4'h1: r_a[15:8]  <= din;
                    4'h2: r_a[23:16] <= din;
                    4'h3: r_a[31:24] <= din;
                    4'h4: r_b[7:0]   <= din;
                    4'h5: r_b[15:8]  <= din;
                    4'h6: r_b[23:16] <= din;
                    4'h7: r_b[31:24] <= din;
                    default: ;
                endcase
            end
            if (w_cmd_ok)  r_op     <= din[3:0];
            if (w_capture) r_result <= fpu_result;
            if (!w_busy)              r_cnt <= '0;
            else if (r_cnt != '1)     r_cnt <= r_cnt + 32'd1;
            r_done <= w_done_next;
            r_err  <= w_err_next;
            r_tmo  <= w_tmo_next;
        end
    end

`ifdef FPU_HOST_IRQ_EN
    logic r_ie, r_irq, w_ie_next;

    assign w_ie_next = w_stat_wr ? din[4] : r_ie;
    assign w_ie      = r_ie;
    assign irq       = r_irq;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_ie_next;
            r_irq <= w_ie_next & (w_done_next | w_tmo_next);
        end
    end
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    assign fpu_op = r_op;
    assign fpu_a  = r_a;
    assign fpu_b  = r_b;

    always_comb begin
        dout = 8'h00;
        if (cs && rd) begin
            case (addr)
                4'h0: dout = r_a[7:0];
                4'h1: dout = r_a[15:8];
                4'h2: dout = r_a[23:16];
                4'h3: dout = r_a[31:24];
                4'h4: dout = r_b[7:0];
                4'h5: dout = r_b[15:8];
                4'h6: dout = r_b[23:16];
                4'h7: dout = r_b[31:24];
                4'h8: dout = {4'h0, r_op};
                4'h9: dout = {3'b000, w_ie, r_tmo, r_err, r_done, w_busy};
                4'hC: dout = r_result[7:0];
                4'hD: dout = r_result[15:8];
                4'hE: dout = r_result[23:16];
                4'hF: dout = r_result[31:24];
                default: dout = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/fpu_host_if.md
# fpu_host_if

Host-side initiator for the FPU command handshake. The block sits between the 8-bit CPU I/O bus and the FPU core. It holds the CPU-written operands and opcode and issues a start request. It waits for the core's done, captures the 32-bit result and completes the four-phase ack. Status, result bytes and an optional interrupt are presented back to the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 4096: abort limit in cycles for one command; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select.
- `wr`  in  1  write strobe, sampled with `cs` at the clock edge.
- `rd`  in  1  read strobe.
- `addr`  in  4  register address.
- `din`  in  8  write data.
- `dout`  out  8  read data; combinational, `0x00` unless `cs & rd`.
- `irq`  out  1  completion interrupt (see Configuration).
- `fpu_op`  out  4  operation code: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 sin, 6 cos, 7 tan, 8 ln, 9 exp.
- `fpu_a`  out  32  operand A.
- `fpu_b`  out  32  operand B.
- `fpu_start`  out  1  request; held high until `fpu_done` is seen.
- `fpu_done`  in  1  core result valid.
- `fpu_result`  in  32  core result; valid while `fpu_done` is high.
- `fpu_ack`  out  1  result taken; held high until `fpu_done` drops.

## Operation
Register map (little-endian bytes):
- 0x0–0x3: A[7:0]..A[31:24], read/write.
- 0x4–0x7: B bytes, read/write.
- 0x8: opcode register, bits [3:0]. A write issues the command.
- 0x9: status. Bit 0 busy (RO), bit 1 done (W1C), bit 2 err (W1C), bit 3 timeout (W1C), bit 4 ie (RW).
- 0xC–0xF: result bytes, read-only.
- Unmapped addresses read `0x00`; writes to them are ignored.

Rules while busy and on command write:
- While busy, writes to 0x0–0x8 are ignored, and a write to 0x8 sets err.
- An opcode greater than 9 sets err, issues no command and leaves the FSM in IDLE.

State machine:
- IDLE
  - On a valid write to 0x8: latch `fpu_op`, clear the timeout counter, go to REQ.
  - `fpu_start = 0`, `fpu_ack = 0`.
- REQ
  - `fpu_start = 1`.
  - `fpu_done` sampled high: latch `fpu_result` into the result register, go to ACK.
  - Counter reaches `TIMEOUT_CYCLES`: set timeout, go to IDLE.
- ACK
  - `fpu_ack = 1`, `fpu_start = 0`.
  - `fpu_done` sampled low: set done, go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES`: set timeout, go to IDLE.
- busy = (state ≠ IDLE).
- The counter increments in REQ and ACK and saturates.
- Result register: written only in REQ on done. A timeout leaves the previous value intact.

Boundary conditions:
- A W1C of done in the same cycle that done is being set: the set wins.
- `fpu_done` already high on entry to REQ: captured on the first REQ edge.
- `fpu_done` dropping in REQ before being sampled: no effect.
- Reset mid-command: all state clears immediately. The core shares `arst`, so no orphaned handshake remains.

## Timing
- Reset values: `dout` = 0, `irq` = 0, `fpu_op` = 0, `fpu_a` = 0, `fpu_b` = 0, `fpu_start` = 0, `fpu_ack` = 0. Status, result and operand registers are 0. FSM in IDLE.
- Opcode write sampled at edge N → `fpu_start` high after edge N.
- `fpu_done` high at edge M → result latched at M; `fpu_start` low and `fpu_ack` high after M.
- `fpu_done` low at edge K → `fpu_ack` low, busy = 0 and done = 1 after K.
- Minimum command time N→K with a zero-latency core is 2 cycles.
- `fpu_a`, `fpu_b` and `fpu_op` are stable from N until return to IDLE.
- `dout` reflects the register state after the most recent edge.

## Configuration
- `FPU_HOST_IRQ_EN` defined:
  - `irq` = ie & (done | timeout), registered and level-held until cleared.
  - Status bit 4 is writable.
- `FPU_HOST_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - Status bit 4 reads 0 and ignores writes.
  - Software polls busy/done.

## Test plan
- Add: A = 0x3FC00000, B = 0x40100000, op 0, core model returns 0x40700000 after 5 cycles.
  - Required: start held 5 cycles, one-cycle ack phase, result bytes 0x00, 0x00, 0x70, 0x40 read from 0xC–0xF.
  - Required: status = 0x02.
- Mul 0x40000000 × 0x40400000, core returns 0x40C00000. Then write 0x02 to 0x9.
  - Required: done clears, status = 0x00.
- Opcode write 0x0A.
  - Required: `fpu_start` never rises, status = 0x04.
- Write 0x8 and 0x0 while busy.
  - Required: err set, `fpu_a`/`fpu_op` unchanged, command completes normally.
- `TIMEOUT_CYCLES` = 16, core never asserts done.
  - Required: `fpu_start` drops after 16 REQ cycles, status = 0x08, result register unchanged.
  - Required: with ie = 1 and the macro defined, `irq` = 1.
- Assert `arst` low during ACK.
  - Required: `fpu_ack`, `fpu_start` and `irq` at 0 immediately, status = 0x00 after release.
